// File: rtl/cpr_pkg.sv
// Shared definitions for the CPR output stage: stream FSM encoding and the
// width of the absolute s coordinate derived from the parent start index.
package cpr_pkg;

  // Stream life cycle of the output buffer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cpr_state_e;

  // Absolute coordinate is the parent start index scaled by the local
  // coordinate range, so it needs the sum of both widths.
  function automatic int sabs_width(input int fdssi_w, input int s_w);
    return fdssi_w + s_w;
  endfunction

endpackage

// File: rtl/cpr_fifo.sv
// Synchronous FIFO with a registered head entry. The head register is loaded
// one cycle after a write into an empty FIFO, and otherwise tracks the slot
// the read pointer moves to, so data_o never changes while nothing is popped.
module cpr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  // A full FIFO refuses writes even if the head is popped the same cycle.
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_q;

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign level_o = level_q;

  // Next pointers, occupancy and head entry.
  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
    valid_d = (level_d != '0);
    head_d  = head_q;
    if (valid_d) begin
      // The slot being written this cycle becomes the head only when it is
      // exactly where the read pointer lands; bypass the array for it.
      if (do_push && (wptr_q == rptr_d)) begin
        head_d = data_i;
      end else begin
        head_d = mem_q[rptr_d];
      end
    end
  end

  // Storage array, written at the tail; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/cpr_out_buf.sv
// Output buffer behind the CPR comparator: queues winners with their absolute
// coordinate, tracks the stream life cycle, flags out-of-order input and
// counts accepted entries.
module cpr_out_buf
  import cpr_pkg::*;
#(
  parameter int FDSSI_W = 12,
  parameter int SSI_W   = 8,
  parameter int S_W     = 2,
  parameter int FDSTI_W = 28,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_i,
  input  logic                                wt_i,
  input  logic [FDSSI_W-1:0]                  FDSSI_i,
  input  logic [SSI_W-1:0]                    SSI_i,
  input  logic [S_W-1:0]                      s_i,
  input  logic [FDSTI_W-1:0]                  FDSTI_i,
  output logic                                ready_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [FDSSI_W-1:0]                  FDSSI_o,
  output logic [SSI_W-1:0]                    SSI_o,
  output logic [S_W-1:0]                      s_o,
  output logic [FDSTI_W-1:0]                  FDSTI_o,
  output logic [sabs_width(FDSSI_W, S_W)-1:0] s_abs_o,
  output logic                                done_o,
  output logic                                order_err_o,
  output logic [CNT_W-1:0]                    count_o
);

  localparam int SABS_W = sabs_width(FDSSI_W, S_W);
  localparam int ENT_W  = FDSSI_W + SSI_W + S_W + FDSTI_W + SABS_W;
  localparam int LW     = $clog2(DEPTH+1);

  cpr_state_e        state_q, state_d;
  logic [SABS_W-1:0] s_abs;
  logic [SABS_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              restart;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_valid;
  logic [LW-1:0]     fifo_level;
  logic [ENT_W-1:0]  fifo_din;
  logic [ENT_W-1:0]  fifo_dout;

  // Modulo arithmetic: operands are cast to the result width before summing.
  assign s_abs = (SABS_W'(FDSSI_i) << S_W) + SABS_W'(SSI_i) + SABS_W'(s_i);

  assign accept   = valid_i && ready_o;
  assign pop      = fifo_valid && ready_i;
  assign fifo_din = {FDSSI_i, SSI_i, s_i, FDSTI_i, s_abs};

  cpr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (fifo_din),
    .pop_i   (ready_i),
    .full_o  (fifo_full),
    .valid_o (fifo_valid),
    .data_o  (fifo_dout),
    .level_o (fifo_level)
  );

  assign valid_o = fifo_valid;
  assign {FDSSI_o, SSI_o, s_o, FDSTI_o, s_abs_o} = fifo_dout;
  assign done_o      = (state_q == ST_DONE);
  assign order_err_o = err_q;
  assign count_o     = count_q;

  // Stream FSM: next state, upstream ready and restart detection.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = !fifo_full;
        if (valid_i && !fifo_full) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ready_o = !fifo_full;
        if (!valid_i && !wt_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Done as soon as the last entry leaves, counting a pop this cycle.
        if ((fifo_level == '0) || ((fifo_level == LW'(1)) && pop)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // FIFO is empty here, so a new winner is always accepted.
        ready_o = valid_i;
        if (valid_i) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Order check and saturating accept counter; a restart opens a new stream.
  always_comb begin
    count_d     = count_q;
    err_d       = err_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (restart) begin
      count_d     = '0;
      err_d       = 1'b0;
      have_prev_d = 1'b0;
    end
    if (accept) begin
      if (have_prev_d && (s_abs < prev_q)) begin
        err_d = 1'b1;
      end
      prev_d      = s_abs;
      have_prev_d = 1'b1;
      if (count_d != '1) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  // State, order-check and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_cpr_out_buf.sv
// Randomised bench for cpr_out_buf with a queue-based reference model and a
// separate monitor that checks every presented head entry.
module tb_cpr_out_buf;

  localparam int FDSSI_W = 12;
  localparam int SSI_W   = 8;
  localparam int S_W     = 2;
  localparam int FDSTI_W = 28;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int SABS_W  = FDSSI_W + S_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, valid_i, wt_i, ready_i;
  logic [FDSSI_W-1:0] FDSSI_i, FDSSI_o;
  logic [SSI_W-1:0]   SSI_i, SSI_o;
  logic [S_W-1:0]     s_i, s_o;
  logic [FDSTI_W-1:0] FDSTI_i, FDSTI_o;
  logic [SABS_W-1:0]  s_abs_o;
  logic               ready_o, valid_o, done_o, order_err_o;
  logic [CNT_W-1:0]   count_o;

  cpr_out_buf #(
    .FDSSI_W(FDSSI_W), .SSI_W(SSI_W), .S_W(S_W), .FDSTI_W(FDSTI_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .wt_i(wt_i),
    .FDSSI_i(FDSSI_i), .SSI_i(SSI_i), .s_i(s_i), .FDSTI_i(FDSTI_i),
    .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .FDSSI_o(FDSSI_o), .SSI_o(SSI_o), .s_o(s_o), .FDSTI_o(FDSTI_o),
    .s_abs_o(s_abs_o), .done_o(done_o), .order_err_o(order_err_o),
    .count_o(count_o)
  );

  typedef struct {
    int unsigned fdssi;
    int unsigned ssi;
    int unsigned s;
    int unsigned fdsti;
    int unsigned sabs;
  } ent_t;

  ent_t sb[$];

  // Reference model of the stream as seen from outside.
  bit          started, finished, done_m, have_prev, err_m, just_reset;
  int unsigned prev_m, cnt_m;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input bit rst, input bit v, input bit wt,
                      input int unsigned fd, input int unsigned ss,
                      input int unsigned sv, input int unsigned ft,
                      input bit rdy);
    bit ready_exp, valid_exp, accept, pop_now, was_done, was_fin, was_started;
    int unsigned fdm, ssm, svm, ftm, sabs;
    ent_t e;
    @(posedge clk);
    #1;
    rst_n   = rst;
    valid_i = v;
    wt_i    = wt;
    fdm     = fd & ((32'd1 << FDSSI_W) - 1);
    ssm     = ss & ((32'd1 << SSI_W) - 1);
    svm     = sv & ((32'd1 << S_W) - 1);
    ftm     = ft & ((32'd1 << FDSTI_W) - 1);
    FDSSI_i = FDSSI_W'(fdm);
    SSI_i   = SSI_W'(ssm);
    s_i     = S_W'(svm);
    FDSTI_i = FDSTI_W'(ftm);
    ready_i = rdy;
    @(negedge clk);
    if (!rst) begin
      sb.delete();
      started = 0; finished = 0; done_m = 0; have_prev = 0;
      err_m = 0; cnt_m = 0; just_reset = 1;
      $display("cycle rst");
      return;
    end
    valid_exp = (sb.size() > 0);
    ready_exp = done_m ? v : (!finished && (sb.size() < DEPTH));
    chk("ready_o", ready_o, ready_exp);
    chk("valid_o", valid_o, valid_exp);
    chk("done_o", done_o, done_m);
    chk("count_o", count_o, cnt_m);
    chk("order_err_o", order_err_o, err_m);
    if (just_reset) begin
      chk("rst_fields", {FDSSI_o, SSI_o, s_o, FDSTI_o, s_abs_o}, 0);
      just_reset = 0;
    end
    accept      = v && ready_exp;
    pop_now     = valid_exp && rdy;
    was_done    = done_m;
    was_fin     = finished;
    was_started = started;
    if (was_fin && !was_done && (sb.size() - int'(pop_now) == 0)) done_m = 1;
    if (was_done && accept) begin
      done_m = 0; finished = 0; cnt_m = 0; err_m = 0; have_prev = 0;
    end
    if (was_started && !was_fin && !v && !wt) finished = 1;
    if (accept) begin
      started = 1;
      sabs = ((fdm << S_W) + ssm + svm) % (32'd1 << SABS_W);
      if (have_prev && (sabs < prev_m)) err_m = 1;
      prev_m    = sabs;
      have_prev = 1;
      if (cnt_m < CNT_MAX) cnt_m++;
      e.fdssi = fdm; e.ssi = ssm; e.s = svm; e.fdsti = ftm; e.sabs = sabs;
      sb.push_back(e);
    end
    $display("cycle v=%0b wt=%0b rdy=%0b acc=%0b s_abs=%0d occ=%0d done=%0b err=%0b cnt=%0d",
             v, wt, rdy, accept, accept ? sabs : 0, sb.size(), done_m, err_m, cnt_m);
  endtask

  // Monitor: every presented head must match the oldest outstanding entry.
  always @(negedge clk) begin
    ent_t e;
    #1;
    if (rst_n && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected: got s_abs=%0d expected no entry", s_abs_o);
      end else begin
        e = sb[0];
        chk("head_fdssi", FDSSI_o, e.fdssi);
        chk("head_ssi", SSI_o, e.ssi);
        chk("head_s", s_o, e.s);
        chk("head_fdsti", FDSTI_o, e.fdsti);
        chk("head_s_abs", s_abs_o, e.sabs);
        if (ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int unsigned base;
    bit v, wt, rdy, rst;
    int unsigned fd, ss, sv;
    rst_n = 0; valid_i = 0; wt_i = 0; ready_i = 0;
    FDSSI_i = '0; SSI_i = '0; s_i = '0; FDSTI_i = '0;
    started = 0; finished = 0; done_m = 0; have_prev = 0; err_m = 0;
    just_reset = 0; prev_m = 0; cnt_m = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);          // end marker ignored in IDLE
    step(1, 0, 1, 0, 0, 0, 0, 0);

    // First entry on an empty FIFO: s_abs = (1<<2)+0+1 = 5.
    step(1, 1, 0, 1, 0, 1, 'h123, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("first_s_abs", s_abs_o, 5);
    chk("first_count", count_o, 1);

    // Fill to DEPTH with no downstream ready; the fifth is held.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 2 + i, 0, 0, i, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 9, 0, 0, 77, 0);
    chk("full_ready", ready_o, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 0, 0, 1);

    // Ten wait cycles mid-stream keep the stream running.
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0, 0, 0, 1);
    chk("wait_done", done_o, 0);

    // Two entries, end of stream, then drain both.
    step(1, 1, 0, 5, 0, 0, 1, 0);
    step(1, 1, 0, 6, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    chk("drain_done", done_o, 1);

    // Restart from DONE with s_abs 8 then 6.
    step(1, 1, 0, 2, 0, 0, 3, 1);
    step(1, 1, 0, 1, 2, 0, 4, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0, 0, 1);
    chk("order_err_sticky", order_err_o, 1);

    // Randomised traffic: monotone streams first, then arbitrary values.
    base = 0;
    for (int n = 0; n < 1600; n++) begin
      rst = ($urandom_range(0, 399) != 0);
      v   = ($urandom_range(0, 3) != 0);
      wt  = v ? 1'b1 : ($urandom_range(0, 39) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (n < 800) begin
        fd = base; ss = 0; sv = 0;
        base = base + $urandom_range(0, 1);
        if (base > 4000) base = 0;
      end else begin
        fd = $urandom; ss = $urandom; sv = $urandom;
      end
      step(rst, v, wt, fd, ss, sv, $urandom, rdy);
    end

    // Reset with three entries buffered.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 10 + i, 1, 1, i, 0);
    chk("pre_rst_valid", valid_o, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);          // checks reset values, IDLE ignores end
    chk("post_rst_count", count_o, 0);
    step(1, 1, 0, 3, 3, 3, 9, 1);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpr_out_buf.md
CPR_OUT_BUF -- requirements
Module: cpr_out_buf

Interface
REQ-001 SHALL have parameter FDSSI_W, default 12, parent-domain start index width.
REQ-002 SHALL have parameter SSI_W, default 8, sub-start index width.
REQ-003 SHALL have parameter S_W, default 2, local s coordinate width.
REQ-004 SHALL have parameter FDSTI_W, default 28, parent-domain tag width.
REQ-005 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-006 SHALL have parameter CNT_W, default 16, accepted-entry counter width.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 valid_i  in  1  comparator winner valid.
REQ-010 wt_i  in  1  with valid_i=0: 1 = wait for more data, 0 = stream finished.
REQ-011 FDSSI_i / SSI_i / s_i / FDSTI_i  in  FDSSI_W / SSI_W / S_W / FDSTI_W  winner fields.
REQ-012 ready_o  out  1  buffer can accept; high when FIFO not full.
REQ-013 valid_o  out  1  head entry valid.
REQ-014 ready_i  in  1  downstream accepts the head entry.
REQ-015 FDSSI_o / SSI_o / s_o / FDSTI_o  out  same widths  head entry fields.
REQ-016 s_abs_o  out  FDSSI_W+S_W  absolute coordinate of the head entry.
REQ-017 done_o  out  1  stream finished and FIFO drained.
REQ-018 order_err_o  out  1  sticky; accepted stream not non-decreasing in s_abs.
REQ-019 count_o  out  CNT_W  number of entries accepted since reset or restart.

Function
REQ-020 Accept SHALL occur when valid_i && ready_o, writing all four fields plus computed s_abs into the FIFO tail.
REQ-021 s_abs SHALL be (FDSSI_i << S_W) + SSI_i + s_i, computed modulo 2^(FDSSI_W+S_W).
REQ-022 Pop SHALL occur when valid_o && ready_i; valid_o and the _o fields SHALL be registered FIFO head values; latency is 1 cycle from accept to valid_o when the FIFO is empty.
REQ-023 Simultaneous accept and pop SHALL leave occupancy unchanged; when full with ready_i=1, ready_o SHALL remain 0 that cycle (no pass-through).
REQ-024 Output fields SHALL hold stable while valid_o && !ready_i.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a 0..DEPTH counter.
REQ-026 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-027 IDLE -> RUN on the first accept; IDLE ignores valid_i=0 && wt_i=0.
REQ-028 RUN -> DRAIN on a cycle with valid_i=0 && wt_i=0; valid_i=0 && wt_i=1 stays in RUN.
REQ-029 DRAIN -> DONE when occupancy reaches 0, including via a pop that cycle; ready_o SHALL be 0 in DRAIN and DONE.
REQ-030 done_o SHALL be 1 only in DONE; DONE -> RUN on valid_i=1, clearing count_o and order_err_o and accepting the entry (restart), with ready_o=1 in that case only.
REQ-031 order_err_o SHALL be set when an accepted s_abs is less than the previously accepted s_abs within the same stream; the first entry of a stream never sets it.
REQ-032 count_o SHALL increment per accept and saturate at 2^CNT_W-1.

Reset
REQ-033 With rst_n=0 at a clock edge: state IDLE, pointers and occupancy 0, valid_o=0, done_o=0, order_err_o=0, count_o=0, _o data fields 0, ready_o=1 after reset release.
REQ-034 Reset mid-stream SHALL discard all FIFO contents and the previous-s_abs register without emitting the discarded entries.

Structure
REQ-035 FSM state encoding and the s_abs width function SHALL live in a shared package cpr_pkg, reused by cpr_2.
REQ-036 Storage SHALL be one sub-module cpr_fifo (parameterised width/depth, synchronous, registered head); the FSM, order check and counter remain in cpr_out_buf.

Verification
REQ-037 Push FDSSI=1,SSI=0,s=1 on an empty FIFO -> valid_o next cycle, s_abs_o=5, count_o=1.
REQ-038 Hold ready_i=0, push 4 entries -> ready_o=0 after the fourth; the fifth is held upstream and the outputs stay stable.
REQ-039 Push s_abs 8 then 6 -> order_err_o=1 and stays set until reset or restart.
REQ-040 Push 2 entries, send valid_i=0,wt_i=0, then pop both -> DRAIN, then done_o=1 the cycle after the last pop.
REQ-041 Send valid_i=0,wt_i=1 for 10 cycles mid-stream -> state stays RUN, done_o=0.
REQ-042 Drive rst_n=0 with 3 entries buffered -> valid_o=0, count_o=0, state IDLE next cycle.
